// File: rtl/phase_addr_gen.sv
// phase_addr_gen
//   Initiator side of a three-phase waveform lookup table. A phase accumulator
//   advances by the frequency word once per programmable tick. The top
//   ADDR_BITS of the accumulator address the table. The three phase-shifted
//   samples returned combinationally are registered one cycle later, and a
//   valid strobe is raised with them. Frequency words offered while running
//   are held pending and applied only at an accumulator wrap, which keeps the
//   output phase continuous.
//
// Ports
//   clk, rst_n           rising-edge clock, synchronous active-low reset
//   run                  1 = generate, 0 = pause (phase retained)
//   div                  tick period = max(div,1)+1 clocks
//   fword/_valid/_ready  frequency word handshake
//   rom_addr, rom_en     table address (registered) and enable
//   rom_d1..rom_d3       table samples for phases A/B/C (combinational)
//   smp_a..smp_c         registered samples
//   smp_valid            one-cycle pulse when smp_* update
//   wrap                 one-cycle pulse when the accumulator carried on a tick
module phase_addr_gen #(
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned ADDR_BITS  = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic [DIV_WIDTH-1:0]  div,
  input  logic [ACC_WIDTH-1:0]  fword,
  input  logic                  fword_valid,
  output logic                  fword_ready,
  output logic [ADDR_BITS-1:0]  rom_addr,
  output logic                  rom_en,
  input  logic [DATA_WIDTH-1:0] rom_d1,
  input  logic [DATA_WIDTH-1:0] rom_d2,
  input  logic [DATA_WIDTH-1:0] rom_d3,
  output logic [DATA_WIDTH-1:0] smp_a,
  output logic [DATA_WIDTH-1:0] smp_b,
  output logic [DATA_WIDTH-1:0] smp_c,
  output logic                  smp_valid,
  output logic                  wrap
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;

  logic [ACC_WIDTH-1:0]   acc;
  logic [ACC_WIDTH-1:0]   fword_reg;
  logic [ACC_WIDTH-1:0]   pend;
  logic                   pend_v;
  logic [DIV_WIDTH-1:0]   tick_cnt;

  logic [DIV_WIDTH-1:0]   div_eff;
  logic [ACC_WIDTH:0]     sum;
  logic                   tick;
  logic                   hs;
  logic                   apply_wrap;
  logic                   apply_idle;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and tick decision
  always_comb begin
    state_nxt  = state;
    tick       = 1'b0;
    // div=0 is clamped to 1 so the minimum tick period is two clocks
    div_eff    = (div == '0) ? DIV_WIDTH'(1) : div;
    sum        = {1'b0, acc} + {1'b0, fword_reg};
    hs         = fword_valid && fword_ready;

    unique case (state)
      IDLE: begin
        if (run) state_nxt = RUN;
      end
      RUN: begin
        // A due tick wins over run=0 so a started period always completes
        if (tick_cnt == div_eff) begin
          tick      = 1'b1;
          state_nxt = CAPTURE;
        end else if (!run) begin
          state_nxt = IDLE;
        end
      end
      CAPTURE: begin
        state_nxt = run ? RUN : IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // The carrying tick still adds the old word; the pending word replaces it
    // after that addition, keeping the phase continuous across the change.
    apply_wrap = tick && sum[ACC_WIDTH] && pend_v;
    // Paused: no wrap is coming, so a pending word is applied right away.
    apply_idle = pend_v && ((state == IDLE) || (state_nxt == IDLE));
  end

  assign rom_en = (state == RUN) || (state == CAPTURE);

  // Datapath: accumulator, tick counter, frequency handshake, sample capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc         <= '0;
      fword_reg   <= '0;
      pend        <= '0;
      pend_v      <= 1'b0;
      fword_ready <= 1'b1;
      tick_cnt    <= '0;
      rom_addr    <= '0;
      smp_a       <= '0;
      smp_b       <= '0;
      smp_c       <= '0;
      smp_valid   <= 1'b0;
      wrap        <= 1'b0;
    end else begin
      smp_valid <= 1'b0;
      wrap      <= 1'b0;

      // fword_ready is low exactly while a word is pending, so a handshake
      // and an apply can never land on the same edge.
      if (hs) begin
        if (state == IDLE) begin
          fword_reg <= fword;
        end else begin
          pend        <= fword;
          pend_v      <= 1'b1;
          fword_ready <= 1'b0;
        end
      end

      if (apply_wrap || apply_idle) begin
        fword_reg   <= pend;
        pend_v      <= 1'b0;
        fword_ready <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          tick_cnt <= '0;
        end
        RUN: begin
          if (tick) begin
            acc      <= sum[ACC_WIDTH-1:0];
            rom_addr <= sum[ACC_WIDTH-1 -: ADDR_BITS];
            wrap     <= sum[ACC_WIDTH];
            tick_cnt <= '0;
          end else if (state_nxt == IDLE) begin
            tick_cnt <= '0;
          end else begin
            tick_cnt <= tick_cnt + DIV_WIDTH'(1);
          end
        end
        CAPTURE: begin
          smp_a     <= rom_d1;
          smp_b     <= rom_d2;
          smp_c     <= rom_d3;
          smp_valid <= 1'b1;
          tick_cnt  <= (state_nxt == IDLE) ? '0 : tick_cnt + DIV_WIDTH'(1);
        end
        default: begin
          tick_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase_addr_gen.sv
// Self-checking bench for phase_addr_gen. A table model supplies
// d1 = addr + 0x0101, d2 = addr ^ 0xA5A5, d3 = ~addr.
module tb_phase_addr_gen;

  localparam int unsigned AW  = 32;
  localparam int unsigned AB  = 16;
  localparam int unsigned DW  = 16;
  localparam int unsigned DVW = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           run;
  logic [DVW-1:0] div;
  logic [AW-1:0]  fword;
  logic           fword_valid;
  logic           fword_ready;
  logic [AB-1:0]  rom_addr;
  logic           rom_en;
  logic [DW-1:0]  rom_d1, rom_d2, rom_d3;
  logic [DW-1:0]  smp_a, smp_b, smp_c;
  logic           smp_valid;
  logic           wrap;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign rom_d1 = rom_addr + 16'h0101;
  assign rom_d2 = rom_addr ^ 16'hA5A5;
  assign rom_d3 = ~rom_addr;

  phase_addr_gen #(
    .ACC_WIDTH (AW),
    .ADDR_BITS (AB),
    .DATA_WIDTH(DW),
    .DIV_WIDTH (DVW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .div        (div),
    .fword      (fword),
    .fword_valid(fword_valid),
    .fword_ready(fword_ready),
    .rom_addr   (rom_addr),
    .rom_en     (rom_en),
    .rom_d1     (rom_d1),
    .rom_d2     (rom_d2),
    .rom_d3     (rom_d3),
    .smp_a      (smp_a),
    .smp_b      (smp_b),
    .smp_c      (smp_c),
    .smp_valid  (smp_valid),
    .wrap       (wrap)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until smp_valid, reporting cycles used and whether wrap pulsed.
  task automatic wait_smp(input int maxc, output int cyc, output bit got, output bit wrap_any);
    cyc = 0; got = 1'b0; wrap_any = 1'b0;
    while (cyc < maxc && !got) begin
      step();
      cyc++;
      if (wrap === 1'b1) wrap_any = 1'b1;
      if (smp_valid === 1'b1) got = 1'b1;
    end
  endtask

  task automatic load_idle(input logic [AW-1:0] w);
    fword = w; fword_valid = 1'b1;
    step();
    fword_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; div = '0; fword = '0; fword_valid = 1'b0;
    step(); step();
    total++; if (rom_addr !== 16'h0000) begin bad++; $display("FAIL reset_addr got=%h exp=0000", rom_addr); end
    total++; if ({smp_a, smp_b, smp_c} !== 48'h0) begin bad++; $display("FAIL reset_smp got=%h %h %h exp=0", smp_a, smp_b, smp_c); end
    total++; if ({rom_en, smp_valid, wrap} !== 3'b000) begin bad++; $display("FAIL reset_ctl got en/v/w=%b%b%b exp=000", rom_en, smp_valid, wrap); end
    total++; if (fword_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", fword_ready); end
    rst_n = 1'b1;
  endtask

  // Quarter-turn word, div=3: ticks every 4 clocks, wrap only on 0x0000.
  task automatic test_basic();
    logic [AB-1:0] ea [4] = '{16'h4000, 16'h8000, 16'hC000, 16'h0000};
    logic [47:0] ed;
    int cyc; bit got, wa;
    load_idle(32'h4000_0000);
    total++; if (fword_ready !== 1'b1) begin bad++; $display("FAIL basic_idle_ready got=%b exp=1", fword_ready); end
    div = 16'd3; run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_smp(20, cyc, got, wa);
      ed = {ea[i] + 16'h0101, ea[i] ^ 16'hA5A5, ~ea[i]};
      total++; if (!got) begin bad++; $display("FAIL basic_timeout[%0d] no smp_valid within 20 cycles", i); end
      total++; if (rom_addr !== ea[i]) begin bad++; $display("FAIL basic_addr[%0d] got=%h exp=%h", i, rom_addr, ea[i]); end
      total++; if ({smp_a, smp_b, smp_c} !== ed) begin bad++; $display("FAIL basic_smp[%0d] got=%h%h%h exp=%h", i, smp_a, smp_b, smp_c, ed); end
      total++; if (wa !== (i == 3)) begin bad++; $display("FAIL basic_wrap[%0d] got=%b exp=%b", i, wa, (i == 3)); end
      total++; if (cyc != ((i == 0) ? 6 : 4)) begin bad++; $display("FAIL basic_period[%0d] got=%0d exp=%0d", i, cyc, (i == 0) ? 6 : 4); end
    end
  endtask

  // Park the accumulator at 0xFFFF0000, then step by one address with div=0.
  task automatic test_clamp_wrap();
    logic [AB-1:0] ea [3] = '{16'h0000, 16'h0001, 16'h0002};
    int ec [3] = '{4, 2, 2};
    int cyc; bit got, wa;
    run = 1'b0;
    step(); step(); step();
    total++; if (rom_en !== 1'b0) begin bad++; $display("FAIL clamp_idle_en got=%b exp=0", rom_en); end
    load_idle(32'hFFFF_0000);
    div = 16'd3; run = 1'b1;
    wait_smp(20, cyc, got, wa);
    total++; if (!got || rom_addr !== 16'hFFFF || wa !== 1'b0) begin bad++; $display("FAIL clamp_preload got=%b addr=%h wrap=%b exp=1 FFFF 0", got, rom_addr, wa); end
    run = 1'b0;
    step(); step();
    load_idle(32'h0001_0000);
    div = 16'd0; run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_smp(20, cyc, got, wa);
      total++; if (!got) begin bad++; $display("FAIL clamp_timeout[%0d] no smp_valid", i); end
      total++; if (rom_addr !== ea[i]) begin bad++; $display("FAIL clamp_addr[%0d] got=%h exp=%h", i, rom_addr, ea[i]); end
      total++; if (wa !== (i == 0)) begin bad++; $display("FAIL clamp_wrap[%0d] got=%b exp=%b", i, wa, (i == 0)); end
      total++; if (cyc != ec[i]) begin bad++; $display("FAIL clamp_period[%0d] got=%0d exp=%0d", i, cyc, ec[i]); end
    end
  endtask

  // Word change offered at 0x4000 on the same edge as a tick.
  task automatic test_handshake();
    logic [AB-1:0] ea [5] = '{16'h8000, 16'hC000, 16'h0000, 16'h2000, 16'h4000};
    bit er [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bit ew [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int ec [5] = '{1, 2, 2, 2, 2};
    int cyc; bit got, wa;
    rst_n = 1'b0; run = 1'b0;
    step();
    rst_n = 1'b1;
    load_idle(32'h4000_0000);
    div = 16'd1; run = 1'b1;
    wait_smp(20, cyc, got, wa);
    total++; if (!got || rom_addr !== 16'h4000 || fword_ready !== 1'b1) begin bad++; $display("FAIL hs_start got=%b addr=%h rdy=%b exp=1 4000 1", got, rom_addr, fword_ready); end
    fword = 32'h2000_0000; fword_valid = 1'b1;
    step();
    fword_valid = 1'b0;
    total++; if (fword_ready !== 1'b0) begin bad++; $display("FAIL hs_ready_drop got=%b exp=0", fword_ready); end
    total++; if (rom_addr !== 16'h8000) begin bad++; $display("FAIL hs_same_edge_addr got=%h exp=8000", rom_addr); end
    for (int i = 0; i < 5; i++) begin
      wait_smp(20, cyc, got, wa);
      total++; if (!got || rom_addr !== ea[i]) begin bad++; $display("FAIL hs_addr[%0d] got=%b/%h exp=1/%h", i, got, rom_addr, ea[i]); end
      total++; if (fword_ready !== er[i]) begin bad++; $display("FAIL hs_ready[%0d] got=%b exp=%b", i, fword_ready, er[i]); end
      total++; if (wa !== ew[i]) begin bad++; $display("FAIL hs_wrap[%0d] got=%b exp=%b", i, wa, ew[i]); end
      total++; if (cyc != ec[i]) begin bad++; $display("FAIL hs_period[%0d] got=%0d exp=%0d", i, cyc, ec[i]); end
    end
  endtask

  // run drops during CAPTURE: the sample still completes, then pause.
  task automatic test_run_drop();
    int cyc; bit got, wa;
    step();
    total++; if (rom_addr !== 16'h6000 || rom_en !== 1'b1) begin bad++; $display("FAIL drop_tick addr=%h en=%b exp=6000 1", rom_addr, rom_en); end
    run = 1'b0;
    step();
    total++; if (smp_valid !== 1'b1) begin bad++; $display("FAIL drop_valid got=%b exp=1", smp_valid); end
    total++; if ({smp_a, smp_b, smp_c} !== {16'h6101, 16'hC5A5, 16'h9FFF}) begin bad++; $display("FAIL drop_smp got=%h%h%h exp=6101c5a59fff", smp_a, smp_b, smp_c); end
    total++; if (rom_en !== 1'b0) begin bad++; $display("FAIL drop_en got=%b exp=0", rom_en); end
    step(); step();
    total++; if ({smp_valid, rom_en} !== 2'b00 || rom_addr !== 16'h6000) begin bad++; $display("FAIL drop_idle v/en=%b%b addr=%h exp=00 6000", smp_valid, rom_en, rom_addr); end
    run = 1'b1;
    wait_smp(20, cyc, got, wa);
    total++; if (!got || rom_addr !== 16'h8000) begin bad++; $display("FAIL drop_resume got=%b addr=%h exp=1 8000", got, rom_addr); end
    total++; if (cyc != 4) begin bad++; $display("FAIL drop_resume_period got=%0d exp=4", cyc); end
  endtask

  // Reset with a word pending: pending word is lost, fword_reg returns to 0.
  task automatic test_reset_pending();
    int cyc; bit got, wa;
    fword = 32'h1000_0000; fword_valid = 1'b1;
    step();
    fword_valid = 1'b0;
    total++; if (fword_ready !== 1'b0) begin bad++; $display("FAIL rstp_pending got=%b exp=0", fword_ready); end
    rst_n = 1'b0; run = 1'b0;
    step();
    total++; if (rom_addr !== 16'h0000 || {smp_a, smp_b, smp_c} !== 48'h0) begin bad++; $display("FAIL rstp_data addr=%h smp=%h%h%h exp=0", rom_addr, smp_a, smp_b, smp_c); end
    total++; if ({rom_en, smp_valid, wrap, fword_ready} !== 4'b0001) begin bad++; $display("FAIL rstp_ctl got=%b%b%b%b exp=0001", rom_en, smp_valid, wrap, fword_ready); end
    rst_n = 1'b1; run = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_smp(20, cyc, got, wa);
      total++; if (!got || rom_addr !== 16'h0000 || wa !== 1'b0) begin bad++; $display("FAIL rstp_addr[%0d] got=%b addr=%h wrap=%b exp=1 0000 0", i, got, rom_addr, wa); end
      total++; if ({smp_a, smp_b, smp_c} !== {16'h0101, 16'hA5A5, 16'hFFFF}) begin bad++; $display("FAIL rstp_smp[%0d] got=%h%h%h exp=0101a5a5ffff", i, smp_a, smp_b, smp_c); end
    end
  endtask

  // fword=0 offered while running: applied at the next wrap, then frozen.
  task automatic test_zero_word();
    bit ew [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int ec [5] = '{3, 4, 4, 4, 4};
    int cyc; bit got, wa;
    rst_n = 1'b0; run = 1'b0;
    step();
    rst_n = 1'b1;
    load_idle(32'h8000_0000);
    div = 16'd3; run = 1'b1;
    wait_smp(20, cyc, got, wa);
    total++; if (!got || rom_addr !== 16'h8000) begin bad++; $display("FAIL zero_start got=%b addr=%h exp=1 8000", got, rom_addr); end
    fword = '0; fword_valid = 1'b1;
    step();
    fword_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_smp(20, cyc, got, wa);
      total++; if (!got || rom_addr !== 16'h0000) begin bad++; $display("FAIL zero_addr[%0d] got=%b addr=%h exp=1 0000", i, got, rom_addr); end
      total++; if (wa !== ew[i]) begin bad++; $display("FAIL zero_wrap[%0d] got=%b exp=%b", i, wa, ew[i]); end
      total++; if (cyc != ec[i]) begin bad++; $display("FAIL zero_period[%0d] got=%0d exp=%0d", i, cyc, ec[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp_wrap();
    test_handshake();
    test_run_drop();
    test_reset_pending();
    test_zero_word();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
